// File: rtl/freq_divider_multi.sv
// Call-button latched clock divider: IDLE/RUN/DRAIN FSM generating clk/tick with fast/slow half-periods.
// Press-to-req latency 3 clk_50 edges; first clk rise HALF cycles after entering RUN; no backpressure.
module freq_divider_multi #(
    parameter int CLK_DIV       = 10,
    parameter int N_BUTTONS     = 3,
    parameter int DRAIN_PERIODS = 4
) (
    input  logic                 clk_50,
    input  logic                 reset_n,
    input  logic [N_BUTTONS-1:0] button,
    input  logic                 moving,
    input  logic                 slow_mode,
    input  logic [N_BUTTONS-1:0] req_clr,
    output logic                 clk,
    output logic                 tick,
    output logic                 running,
    output logic [N_BUTTONS-1:0] req
);

    localparam int CW = $clog2(2 * CLK_DIV) + 1;
    localparam int DW = $clog2(DRAIN_PERIODS + 1);
    localparam logic [CW-1:0] HALF_FAST  = CW'(CLK_DIV);
    localparam logic [CW-1:0] HALF_SLOW  = CW'(2 * CLK_DIV);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_PERIODS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    logic [N_BUTTONS-1:0] sync1_q, sync2_q, prev_q, press, req_q, req_d;
    logic [1:0]           settle_q;
    logic                 settled;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, half;
    logic [DW-1:0]        drain_q, drain_d;
    logic                 clk_q, clk_d, tick_q, tick_d, mode_q, mode_d;
    logic                 wrap, active;

    // Edge detector stays disarmed until the synchronizer holds a real sample,
    // so a button already held low when reset releases never counts as a press.
    assign settled = (settle_q == 2'd2);
    assign press   = prev_q & ~sync2_q;
    assign req_d   = (req_q & ~req_clr) | press;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            prev_q   <= '0;
            settle_q <= 2'd0;
            req_q    <= '0;
        end else begin
            sync1_q  <= button;
            sync2_q  <= sync1_q;
            prev_q   <= settled ? sync2_q : '0;
            if (!settled) settle_q <= settle_q + 2'd1;
            req_q    <= req_d;
        end
    end

    assign half   = mode_q ? HALF_SLOW : HALF_FAST;
    assign wrap   = (cnt_q == half - CW'(1));
    assign active = moving | (|req_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        mode_d  = mode_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (active) begin
                    state_d = RUN;
                    mode_d  = slow_mode;
                end
            end
            RUN, DRAIN: begin
                if (wrap) begin
                    cnt_d  = '0;
                    clk_d  = ~clk_q;
                    tick_d = ~clk_q;
                    if (clk_q) mode_d = slow_mode;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (state_q == RUN) begin
                    if (wrap && clk_q && !active) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end else if (active) begin
                    // Divider phase carries over untouched; only the drain count is dropped.
                    state_d = RUN;
                    drain_d = '0;
                end else if (wrap && clk_q) begin
                    drain_d = drain_q - DW'(1);
                    if (drain_q <= DW'(1)) begin
                        state_d = IDLE;
                        drain_d = '0;
                        cnt_d   = '0;
                        clk_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drain_q <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            mode_q  <= mode_d;
        end
    end

    assign clk     = clk_q;
    assign tick    = tick_q;
    assign running = (state_q != IDLE);
    assign req     = req_q;

endmodule

// File: tb/tb_freq_divider_multi.sv
// Directed bench for freq_divider_multi: CLK_DIV=10, N_BUTTONS=3, DRAIN_PERIODS=4.
module tb_freq_divider_multi;

    logic       clk_50 = 1'b0;
    logic       reset_n;
    logic [2:0] button;
    logic       moving;
    logic       slow_mode;
    logic [2:0] req_clr;
    logic       dclk, tick, running;
    logic [2:0] req;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    freq_divider_multi #(.CLK_DIV(10), .N_BUTTONS(3), .DRAIN_PERIODS(4)) dut (
        .clk_50   (clk_50),
        .reset_n  (reset_n),
        .button   (button),
        .moving   (moving),
        .slow_mode(slow_mode),
        .req_clr  (req_clr),
        .clk      (dclk),
        .tick     (tick),
        .running  (running),
        .req      (req)
    );

    always #5 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    // Waits for dclk to transition into val; returns the cycle stamp of that edge.
    task automatic wait_edge(input logic val, input string tag, output int at);
        logic prev;
        int   start;
        prev  = dclk;
        start = cyc;
        at    = -1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (prev !== val && dclk === val) begin
                at = cyc;
                break;
            end
            prev = dclk;
        end
        if (at < 0) begin
            chk({tag, "_timeout"}, 32'(cyc - start), 32'(0));
            at = cyc;
        end
    endtask

    initial begin
        int t_run, t0, t1, t2, tf, tf2, tf3, tr, tr2, tr3, tr4, t_idle, n;
        reset_n = 1'b0; button = 3'b011; moving = 1'b0; slow_mode = 1'b0; req_clr = 3'b000;
        step(3);
        chk("rst_clk", 32'(dclk), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_req", 32'(req), 0);

        // Button 2 held low across reset release must not register.
        reset_n = 1'b1;
        step(8);
        chk("held_low_no_press", 32'(req), 0);
        chk("idle_running", 32'(running), 0);
        button = 3'b111;
        step(5);
        chk("release_no_press", 32'(req), 0);

        // Press button 0 for 5 cycles; first rise comes 10 cycles after RUN entry.
        t_run = -1;
        button[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) button[0] = 1'b1;
            step(1);
            if (running === 1'b1 && t_run < 0) t_run = cyc;
        end
        if (t_run < 0) begin
            chk("run_start", 32'(running), 1);
            t_run = cyc;
        end
        chk("req_after_press", 32'(req), 1);
        chk("running_after_press", 32'(running), 1);
        wait_edge(1'b1, "first_rise", t1);
        chk("first_rise_delay", 32'(t1 - t_run), 10);
        chk("tick_at_first_rise", 32'(tick), 1);
        step(1);
        chk("tick_one_cycle", 32'(tick), 0);
        wait_edge(1'b0, "fall1", tf);
        chk("fast_high_half", 32'(tf - t1), 10);
        wait_edge(1'b1, "rise2", t2);
        chk("fast_period", 32'(t2 - t1), 20);
        chk("tick_at_rise2", 32'(tick), 1);

        // Hand over to moving, drop the request, then go slow mid high-half.
        moving = 1'b1; req_clr = 3'b001;
        step(1);
        req_clr = 3'b000;
        chk("req_cleared", 32'(req), 0);
        step(3);
        slow_mode = 1'b1;
        wait_edge(1'b0, "slow_f1", tf);
        chk("slow_cur_half", 32'(tf - t2), 10);
        wait_edge(1'b1, "slow_r1", tr);
        chk("slow_low_half", 32'(tr - tf), 20);
        wait_edge(1'b0, "slow_f2", tf2);
        chk("slow_high_half", 32'(tf2 - tr), 20);
        slow_mode = 1'b0;
        wait_edge(1'b1, "slow_r2", tr2);
        chk("slow_low_kept", 32'(tr2 - tf2), 20);
        wait_edge(1'b0, "slow_f3", tf3);
        chk("slow_high_kept", 32'(tf3 - tr2), 20);
        wait_edge(1'b1, "fast_r", tr3);
        chk("fast_again", 32'(tr3 - tf3), 10);

        // Motion ends right after a rise: finish this period, then 4 drain periods.
        moving = 1'b0;
        t0 = cyc; n = 0; t_idle = -1;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (tick === 1'b1) n++;
            if (running === 1'b0) begin
                t_idle = cyc;
                break;
            end
        end
        if (t_idle < 0) t_idle = cyc;
        chk("drain_ticks", 32'(n), 4);
        chk("drain_len", 32'(t_idle - t0), 90);
        chk("idle_clk", 32'(dclk), 0);
        step(25);
        chk("idle_stays", 32'(running), 0);
        chk("idle_no_tick", 32'(tick), 0);

        // Enter DRAIN, press button 2, expect RUN with the phase untouched.
        moving = 1'b1;
        wait_edge(1'b1, "d_rise0", tr);
        moving = 1'b0;
        wait_edge(1'b0, "d_fall0", tf);
        wait_edge(1'b1, "d_rise1", tr2);
        chk("drain_low_half", 32'(tr2 - tf), 10);
        button[2] = 1'b0;
        step(5);
        button[2] = 1'b1;
        wait_edge(1'b0, "d_fall1", tf2);
        chk("press_high_half", 32'(tf2 - tr2), 10);
        chk("req_bit2", 32'(req), 4);
        wait_edge(1'b1, "d_rise2", tr3);
        chk("press_low_half", 32'(tr3 - tf2), 10);
        step(100);
        chk("run_after_drain_press", 32'(running), 1);
        wait_edge(1'b1, "d_rise3", tr4);
        chk("phase_kept", 32'((tr4 - tr3) % 20), 0);

        // Press event on button 1 coincides with req_clr[1]: the press wins.
        button[1] = 1'b0;
        step(2);
        req_clr = 3'b010;
        step(1);
        req_clr = 3'b000;
        chk("press_beats_clear", 32'(req[1]), 1);
        req_clr = 3'b010;
        step(1);
        req_clr = 3'b000;
        chk("clear_alone", 32'(req[1]), 0);
        button[1] = 1'b1;
        step(4);
        chk("release_no_req", 32'(req[1]), 0);

        // Half-cycle glitch on button 0: outcome unconstrained.
        @(posedge clk_50);
        #2 button[0] = 1'b0;
        #3 button[0] = 1'b1;
        step(4);

        // Asynchronous reset while clk is high.
        wait_edge(1'b1, "r_rise", tr);
        step(2);
        chk("pre_reset_clk", 32'(dclk), 1);
        reset_n = 1'b0;
        #1;
        chk("async_clk", 32'(dclk), 0);
        chk("async_tick", 32'(tick), 0);
        chk("async_running", 32'(running), 0);
        chk("async_req", 32'(req), 0);
        step(3);
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (tick === 1'b1) n++;
        end
        chk("no_tick_after_reset", 32'(n), 0);
        chk("idle_after_reset", 32'(running), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
